// File: rtl/parking_gate_pkg.sv
// Shared types and default parameters for the parking gate controller.
package parking_gate_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PIN  = 3'd1,
    OPEN      = 3'd2,
    BLOCKED   = 3'd3,
    PIN_ALARM = 3'd4
  } state_t;

  localparam logic [7:0] DEF_CORRECT_PIN  = 8'b0010_0110;
  localparam int         DEF_MAX_TRIES    = 3;
  localparam int         DEF_WAIT_TIMEOUT = 50;

  // States in which a presented PIN is treated as an attempt.
  function automatic logic is_attempt_state(input state_t s);
    return (s == WAIT_PIN) || (s == BLOCKED) || (s == PIN_ALARM);
  endfunction

endpackage

// File: rtl/parking_gate_controller_pin_checker.sv
// PIN attempt detection (edge on a new non-zero code), correct/wrong decision
// and the persistent wrong-attempt counter.
module pin_checker
  import parking_gate_pkg::*;
#(
  parameter logic [7:0] CORRECT_PIN = DEF_CORRECT_PIN,
  parameter int         MAX_TRIES   = DEF_MAX_TRIES,
  parameter int         CNT_W       = $clog2(MAX_TRIES + 1)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] pass_i,
  input  state_t     state_i,
  input  logic       enter_idle_i,
  input  logic       clr_try_i,
  output logic       correct_o,
  output logic       wrong_o,
  output logic       last_try_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TRIES);

  logic [7:0]       last_pin_q, last_pin_d;
  logic [CNT_W-1:0] try_cnt_q, try_cnt_d;
  logic             attempt;

  // A held code is one attempt; it must drop to 0 before it counts again.
  assign attempt    = is_attempt_state(state_i) && (pass_i != 8'd0) && (pass_i != last_pin_q);
  assign correct_o  = attempt && (pass_i == CORRECT_PIN);
  assign wrong_o    = attempt && (pass_i != CORRECT_PIN);
  assign last_try_o = (try_cnt_q >= (MAX_CNT - CNT_W'(1)));

  always_comb begin
    last_pin_d = last_pin_q;
    if (enter_idle_i)       last_pin_d = 8'd0;
    else if (pass_i == 8'd0) last_pin_d = 8'd0;
    else if (attempt)        last_pin_d = pass_i;
  end

  // Only wrong codes in WAIT_PIN count; BLOCKED and PIN_ALARM ignore them.
  always_comb begin
    try_cnt_d = try_cnt_q;
    if (clr_try_i)
      try_cnt_d = '0;
    else if (wrong_o && (state_i == WAIT_PIN) && (try_cnt_q < MAX_CNT))
      try_cnt_d = try_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_pin_q <= 8'd0;
      try_cnt_q  <= '0;
    end else begin
      last_pin_q <= last_pin_d;
      try_cnt_q  <= try_cnt_d;
    end
  end

endmodule

// File: rtl/parking_gate_controller.sv
// Parking gate FSM with PIN entry, tailgating detection and wait timeout.
// State and all outputs are registered on the same edge.
module parking_gate_controller
  import parking_gate_pkg::*;
#(
  parameter logic [7:0] CORRECT_PIN  = DEF_CORRECT_PIN,
  parameter int         MAX_TRIES    = DEF_MAX_TRIES,
  parameter int         WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensorA,
  input  logic       sensorB,
  input  logic [7:0] pass,
  output logic       gateState,
  output logic       blockAlarm,
  output logic       wrongPinAlarm
);

  localparam int              TMO_W    = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WAIT_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             prev_correct_q, prev_correct_d;
  logic             gate_q, block_q, wrong_alarm_q;
  logic             correct, wrong, last_try, clr_try, enter_idle;

  pin_checker #(
    .CORRECT_PIN (CORRECT_PIN),
    .MAX_TRIES   (MAX_TRIES)
  ) u_pin_checker (
    .clk          (clk),
    .reset_n      (reset_n),
    .pass_i       (pass),
    .state_i      (state_q),
    .enter_idle_i (enter_idle),
    .clr_try_i    (clr_try),
    .correct_o    (correct),
    .wrong_o      (wrong),
    .last_try_o   (last_try)
  );

  assign enter_idle = (state_d == IDLE) && (state_q != IDLE);

  always_comb begin
    state_d        = state_q;
    tmo_d          = '0;
    prev_correct_d = prev_correct_q;
    clr_try        = 1'b0;
    case (state_q)
      IDLE: begin
        if (sensorA) begin
          state_d = WAIT_PIN;
          clr_try = prev_correct_q;
        end
      end
      WAIT_PIN: begin
        if (correct) begin
          state_d        = OPEN;
          clr_try        = 1'b1;
          prev_correct_d = 1'b1;
        end else if (wrong) begin
          if (last_try) state_d = PIN_ALARM;
        end else if (tmo_q == TMO_LAST) begin
          // A vehicle still at the entry keeps the session alive.
          if (!sensorA) begin
            state_d        = IDLE;
            prev_correct_d = 1'b0;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      OPEN: begin
        if (sensorA && sensorB) state_d = BLOCKED;
        else if (sensorB)       state_d = IDLE;
      end
      BLOCKED: begin
        if (correct) begin
          state_d        = IDLE;
          prev_correct_d = 1'b1;
        end
      end
      PIN_ALARM: begin
        if (correct) begin
          state_d        = IDLE;
          clr_try        = 1'b1;
          prev_correct_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      tmo_q          <= '0;
      prev_correct_q <= 1'b0;
      gate_q         <= 1'b0;
      block_q        <= 1'b0;
      wrong_alarm_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      tmo_q          <= tmo_d;
      prev_correct_q <= prev_correct_d;
      gate_q         <= (state_d == OPEN);
      block_q        <= (state_d == BLOCKED);
      wrong_alarm_q  <= (state_d == PIN_ALARM);
    end
  end

  assign gateState     = gate_q;
  assign blockAlarm    = block_q;
  assign wrongPinAlarm = wrong_alarm_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Scoreboard bench: expected outputs are queued when inputs are driven and
// compared one edge later.
module tb_parking_gate_controller;
  import parking_gate_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sensorA = 1'b0;
  logic       sensorB = 1'b0;
  logic [7:0] pass = 8'd0;
  logic       gateState, blockAlarm, wrongPinAlarm;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string      tag;
    logic [2:0] outs;  // {gateState, blockAlarm, wrongPinAlarm}
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  parking_gate_controller dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sensorA       (sensorA),
    .sensorB       (sensorB),
    .pass          (pass),
    .gateState     (gateState),
    .blockAlarm    (blockAlarm),
    .wrongPinAlarm (wrongPinAlarm)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq({e.tag, ".gate"},  32'(gateState),     32'(e.outs[2]));
      check_eq({e.tag, ".block"}, 32'(blockAlarm),    32'(e.outs[1]));
      check_eq({e.tag, ".wrong"}, 32'(wrongPinAlarm), 32'(e.outs[0]));
    end
  end

  task automatic drv(input logic sa, input logic sb, input logic [7:0] pw,
                     input logic [2:0] exp, input string tag);
    exp_t e;
    @(negedge clk);
    sensorA = sa;
    sensorB = sb;
    pass    = pw;
    e.tag   = tag;
    e.outs  = exp;
    sb_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_state(input string tag, input state_t exp_st);
    check_eq({tag, ".state"}, 32'(dut.state_q), 32'(exp_st));
  endtask

  task automatic check_try(input string tag, input int exp_cnt);
    check_eq({tag, ".try_cnt"}, 32'(dut.u_pin_checker.try_cnt_q), 32'(exp_cnt));
  endtask

  task automatic nominal(input string tag);
    for (int i = 0; i < 25; i++) drv(1'b1, 1'b0, 8'h26, (i == 0) ? 3'b000 : 3'b100, tag);
    for (int i = 0; i < 25; i++) drv(1'b0, 1'b0, 8'h00, 3'b100, tag);
    drv(1'b0, 1'b1, 8'h00, 3'b000, tag);
    drv(1'b0, 1'b0, 8'h00, 3'b000, tag);
    settle();
    check_state(tag, IDLE);
    $display("[TB] %s: nominal entry sequence", tag);
  endtask

  task automatic wrong_to_alarm(input string tag);
    drv(1'b1, 1'b0, 8'h00, 3'b000, tag);
    drv(1'b1, 1'b0, 8'h11, 3'b000, tag);
    drv(1'b1, 1'b0, 8'h00, 3'b000, tag);
    drv(1'b1, 1'b0, 8'h12, 3'b000, tag);
    drv(1'b1, 1'b0, 8'h00, 3'b000, tag);
    drv(1'b1, 1'b0, 8'h13, 3'b001, tag);
  endtask

  task automatic reset_pulse(input string tag);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq({tag, ".gate"},  32'(gateState),     32'd0);
    check_eq({tag, ".block"}, 32'(blockAlarm),    32'd0);
    check_eq({tag, ".wrong"}, 32'(wrongPinAlarm), 32'd0);
    check_state(tag, IDLE);
    check_try(tag, 0);
    check_eq({tag, ".last_pin"}, 32'(dut.u_pin_checker.last_pin_q), 32'd0);
    @(negedge clk);
    sensorA = 1'b0;
    sensorB = 1'b0;
    pass    = 8'd0;
    reset_n = 1'b1;
    $display("[TB] %s: asynchronous reset applied", tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_eq("por.gate",  32'(gateState),     32'd0);
    check_eq("por.block", 32'(blockAlarm),    32'd0);
    check_eq("por.wrong", 32'(wrongPinAlarm), 32'd0);
    check_state("por", IDLE);
    @(negedge clk);
    reset_n = 1'b1;

    nominal("nominal1");

    wrong_to_alarm("wrongpin");
    drv(1'b1, 1'b0, 8'h00, 3'b001, "wrongpin");
    drv(1'b1, 1'b0, 8'h14, 3'b001, "wrongpin");
    drv(1'b1, 1'b0, 8'h00, 3'b001, "wrongpin");
    drv(1'b0, 1'b0, 8'h26, 3'b000, "wrongpin");
    settle();
    check_state("wrongpin", IDLE);
    check_try("wrongpin", 0);
    drv(1'b0, 1'b0, 8'h00, 3'b000, "wrongpin");
    $display("[TB] wrongpin: three wrong codes raise alarm, correct clears");

    for (int i = 0; i < 20; i++) drv(1'b1, 1'b0, 8'h11, 3'b000, "repeat");
    settle();
    check_try("repeat", 1);
    check_state("repeat", WAIT_PIN);
    drv(1'b1, 1'b0, 8'h00, 3'b000, "repeat");
    drv(1'b1, 1'b0, 8'h26, 3'b100, "repeat");
    drv(1'b0, 1'b1, 8'h00, 3'b000, "repeat");
    drv(1'b0, 1'b0, 8'h00, 3'b000, "repeat");
    settle();
    check_try("repeat", 0);
    $display("[TB] repeat: held code counted once");

    drv(1'b1, 1'b0, 8'h26, 3'b000, "tailgate");
    drv(1'b1, 1'b0, 8'h26, 3'b100, "tailgate");
    drv(1'b1, 1'b1, 8'h26, 3'b010, "tailgate");
    drv(1'b1, 1'b1, 8'h00, 3'b010, "tailgate");
    drv(1'b1, 1'b1, 8'h55, 3'b010, "tailgate");
    drv(1'b1, 1'b1, 8'h00, 3'b010, "tailgate");
    drv(1'b0, 1'b0, 8'h26, 3'b000, "tailgate");
    settle();
    check_try("tailgate", 0);
    check_state("tailgate", IDLE);
    drv(1'b0, 1'b0, 8'h00, 3'b000, "tailgate");
    $display("[TB] tailgate: blocked until correct code");

    drv(1'b1, 1'b0, 8'h00, 3'b000, "timeout");
    for (int i = 0; i < 49; i++) drv(1'b0, 1'b0, 8'h00, 3'b000, "timeout");
    settle();
    check_state("timeout.49", WAIT_PIN);
    drv(1'b0, 1'b0, 8'h00, 3'b000, "timeout");
    settle();
    check_state("timeout.50", IDLE);
    $display("[TB] timeout: WAIT_PIN left after 50 cycles");

    drv(1'b1, 1'b0, 8'h00, 3'b000, "persist");
    drv(1'b1, 1'b0, 8'h11, 3'b000, "persist");
    drv(1'b1, 1'b0, 8'h00, 3'b000, "persist");
    drv(1'b1, 1'b0, 8'h12, 3'b000, "persist");
    for (int i = 0; i < 50; i++) drv(1'b0, 1'b0, 8'h00, 3'b000, "persist");
    settle();
    check_state("persist", IDLE);
    check_try("persist", 2);
    drv(1'b1, 1'b0, 8'h00, 3'b000, "persist");
    drv(1'b1, 1'b0, 8'h13, 3'b001, "persist");
    drv(1'b1, 1'b0, 8'h00, 3'b001, "persist");
    drv(1'b0, 1'b0, 8'h26, 3'b000, "persist");
    drv(1'b0, 1'b0, 8'h00, 3'b000, "persist");
    settle();
    check_try("persist.clr", 0);
    $display("[TB] persist: wrong attempts carried across vehicles");

    drv(1'b1, 1'b0, 8'h26, 3'b000, "rst_open");
    drv(1'b1, 1'b0, 8'h26, 3'b100, "rst_open");
    settle();
    reset_pulse("rst_open");
    nominal("nominal2");

    wrong_to_alarm("rst_alarm");
    settle();
    reset_pulse("rst_alarm");
    nominal("nominal3");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
